fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter sharing one sync FIFO (16b x 8 default) among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_rr_picker.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults, state type and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

  // Width of a requester index; never below 1 so single-bit vectors stay legal.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// rtl/fifo_rr_picker.sv - rotate-priority encoder: first valid at or after ptr, searching upward with wrap
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = rr_idx_w(NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW:0]          sum;
  logic                 found;

  // Rotate the valid vector so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl   = {valid_i, valid_i};
    rot   = dbl[ptr_i +: NUM_REQ];
    found = 1'b0;
    sum   = '0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IW+1)'(k);
        if (sum >= (IW+1)'(NUM_REQ)) begin
          sum = sum - (IW+1)'(NUM_REQ);
        end
        idx_o = sum[IW-1:0];
      end
    end
    any_o    = found;
    onehot_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter for a shared sync FIFO; FIFO_ARB_ACK_CHECK_EN adds ack_err
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [rr_idx_w(NUM_REQ)-1:0]  grant_id,
  output logic                          busy,
  output logic                          err,
`ifdef FIFO_ARB_ACK_CHECK_EN
  output logic                          ack_err,
`endif
  input  logic                          err_clr
);

  localparam int IW = rr_idx_w(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]       gid_q, gid_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [FIFO_WIDTH-1:0] pick_data;
  logic                space_ok;
  logic                grant_en;
  logic                xfer;

  // Flags lag our registered write by a cycle, so a pending write at almostfull counts as the last slot.
  assign space_ok  = !fifo_full && !(fifo_almostfull && wr_en_q);
  assign grant_en  = (state_q == RUN) && arb_en && space_ok;
  assign req_ready = grant_en ? pick_onehot : '0;
  assign xfer      = grant_en && pick_any;

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Select the winning requester's data slice.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Run/pause next state; leaving RUN already blocks grants through arb_en in grant_en.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE:   if (arb_en)  state_d = RUN;
      RUN:     if (!arb_en) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  // Write-port, pointer and sticky error next values.
  always_comb begin
    wr_en_d  = 1'b0;
    data_d   = data_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      wr_en_d  = 1'b1;
      data_d   = pick_data;
      gid_d    = pick_idx;
      rr_ptr_d = (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
    end
    if (fifo_overflow) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers; reset drops any write in flight and restarts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PAUSE;
      rr_ptr_q <= '0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      err_q    <= err_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id     = gid_q;
  assign err          = err_q;
  assign busy         = (|req_valid) || wr_en_q;

`ifdef FIFO_ARB_ACK_CHECK_EN
  logic wr_en_dly_q;
  logic ack_err_q, ack_err_d;

  // The FIFO acknowledges one cycle after it samples wr_en; any disagreement latches ack_err.
  always_comb begin
    if (fifo_wr_ack != wr_en_dly_q) begin
      ack_err_d = 1'b1;
    end else if (err_clr) begin
      ack_err_d = 1'b0;
    end else begin
      ack_err_d = ack_err_q;
    end
  end

  // Delayed write enable and sticky ack error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_dly_q <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      wr_en_dly_q <= wr_en_q;
      ack_err_q   <= ack_err_d;
    end
  end

  assign ack_err = ack_err_q;

  logic unused_ok;
  assign unused_ok = FIFO_DEPTH[0];
`else
  logic unused_ok;
  assign unused_ok = ^{fifo_wr_ack, FIFO_DEPTH[0]};
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter; FIFO_ARB_ACK_CHECK_EN enables the ack_err phase
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           arb_en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err;
  logic           err_clr;
`ifdef FIFO_ARB_ACK_CHECK_EN
  logic           ack_err;
`endif

  logic [W-1:0] dat [N];
  int           rem [N];
  int           hs_total = 0;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  logic rd_en = 1'b0;
  logic force_ovf = 1'b0;
  logic sup_ack = 1'b0;
  int   cnt = 0;
  logic ack_r = 1'b0;
  logic ovf_r = 1'b0;
  logic real_ovf = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   id;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cycles[$];

  for (genvar g = 0; g < N; g++) begin : g_data
    assign req_data[g*W +: W] = dat[g];
  end

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_en          (arb_en),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .grant_id        (grant_id),
    .busy            (busy),
    .err             (err),
`ifdef FIFO_ARB_ACK_CHECK_EN
    .ack_err         (ack_err),
`endif
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sync FIFO flag model, 8 deep, flags updated at the edge that samples wr_en/rd_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 0;
      ack_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      cnt      <= cnt + ((fifo_wr_en && cnt < D) ? 1 : 0) - ((rd_en && cnt > 0) ? 1 : 0);
      ack_r    <= fifo_wr_en && (cnt < D) && !sup_ack;
      ovf_r    <= fifo_wr_en && (cnt == D);
      real_ovf <= real_ovf | (fifo_wr_en && (cnt == D));
    end
  end

  assign fifo_full       = (cnt == D);
  assign fifo_almostfull = (cnt == D - 1);
  assign fifo_wr_ack     = ack_r;
  assign fifo_overflow   = ovf_r | force_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input int id);
    exp_t e;
    e.d  = d;
    e.id = 2'(id);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string nm, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_hs(input string nm, input int target, input int max);
    int n = 0;
    while (hs_total < target && n < max) begin
      tick();
      n++;
    end
    chk(nm, (hs_total >= target) ? 1 : 0, 1);
  endtask

  // Producer agent: each requester holds valid until its remaining word budget is used up.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          rem[i] = rem[i] - 1;
          hs_total++;
        end
        req_valid[i] = (rem[i] > 0);
      end
    end
  end

  // Scoreboard monitor: every FIFO write must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got data %0h id %0d, required no write", fifo_data_in, grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(fifo_data_in), 32'(e.d));
          chk("wr_id", 32'(grant_id), 32'(e.id));
          wr_cycles.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    err_clr   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) dat[i] = 16'hA000 + 16'(i);
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;

    // Reset with all requesters valid.
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_data_in", 32'(fifo_data_in), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err", 32'(err), 0);

    // Round robin, FIFO read every cycle.
    push_exp(16'hA000, 0); push_exp(16'hA001, 1); push_exp(16'hA002, 2);
    push_exp(16'hA003, 3); push_exp(16'hA000, 0);
    rst_n  = 1'b1;
    arb_en = 1'b1;
    rd_en  = 1'b1;
    wait_drain("rr_drain", 40);
    chk("rr_nwrites", wr_cycles.size(), 5);
    if (wr_cycles.size() >= 5) chk("rr_back_to_back", wr_cycles[4] - wr_cycles[0], 4);
    repeat (3) tick();

    // Fill: only req1, no reads, FIFO must stop at exactly 8 writes.
    rd_en = 1'b0;
    wr_cycles.delete();
    dat[1] = 16'h1111;
    for (int i = 0; i < 9; i++) push_exp(16'h1111, 1);
    rem[1] = 9;
    repeat (20) tick();
    chk("fill_nwrites", wr_cycles.size(), 8);
    chk("fill_req_ready", 32'(req_ready), 0);
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_no_overflow", 32'(real_ovf), 0);
    chk("fill_err", 32'(err), 0);
    chk("fill_busy", 32'(busy), 1);
    rd_en = 1'b1;
    wait_drain("fill_drain", 30);
    repeat (4) tick();

    // Pause mid-stream, resume at the next pointer (order starts at req2).
    for (int i = 0; i < N; i++) dat[i] = 16'hB000 + 16'(i);
    for (int r = 0; r < 2; r++) begin
      push_exp(16'hB002, 2); push_exp(16'hB003, 3);
      push_exp(16'hB000, 0); push_exp(16'hB001, 1);
    end
    base = hs_total;
    for (int i = 0; i < N; i++) rem[i] = 2;
    wait_hs("pause_hs", base + 2, 30);
    arb_en = 1'b0;
    #1;
    chk("pause_ready_now", 32'(req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pause_ready", 32'(req_ready), 0);
      chk("pause_wr_en", 32'(fifo_wr_en), 0);
    end
    arb_en = 1'b1;
    wait_drain("pause_drain", 40);
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 0);

    // Sticky overflow error and clear priority.
    force_ovf = 1'b1;
    tick();
    force_ovf = 1'b0;
    chk("err_set", 32'(err), 1);
    repeat (3) tick();
    chk("err_hold", 32'(err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 0);
    force_ovf = 1'b1;
    err_clr   = 1'b1;
    tick();
    force_ovf = 1'b0;
    err_clr   = 1'b0;
    chk("err_set_wins", 32'(err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr2", 32'(err), 0);

    // Async reset during a burst; arbitration restarts at req0.
    for (int i = 0; i < N; i++) dat[i] = 16'hC000 + 16'(i);
    for (int r = 0; r < 3; r++) begin
      push_exp(16'hC002, 2); push_exp(16'hC003, 3);
      push_exp(16'hC000, 0); push_exp(16'hC001, 1);
    end
    base = hs_total;
    for (int i = 0; i < N; i++) rem[i] = 3;
    wait_hs("rstb_hs", base + 2, 30);
    rst_n = 1'b0;
    #1;
    chk("rstb_wr_en", 32'(fifo_wr_en), 0);
    chk("rstb_data_in", 32'(fifo_data_in), 0);
    chk("rstb_grant_id", 32'(grant_id), 0);
    chk("rstb_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int i = 0; i < N; i++) push_exp(16'hC000 + 16'(i), i);
    tick();
    tick();
    rst_n = 1'b1;
    wait_drain("rstb_drain", 40);
    repeat (4) tick();

`ifdef FIFO_ARB_ACK_CHECK_EN
    // One suppressed write acknowledge must latch ack_err until err_clr.
    for (int i = 0; i < N; i++) dat[i] = 16'hD000 + 16'(i);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) push_exp(16'hD000 + 16'(i), i);
    end
    chk("ack_err_clean", 32'(ack_err), 0);
    base = hs_total;
    for (int i = 0; i < N; i++) rem[i] = 4;
    wait_hs("ack_hs", base + 3, 30);
    sup_ack = 1'b1;
    tick();
    sup_ack = 1'b0;
    for (int k = 0; k < 5 && ack_err !== 1'b1; k++) tick();
    chk("ack_err_set", 32'(ack_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ack_err_clr", 32'(ack_err), 0);
    wait_drain("ack_drain", 40);
    repeat (4) tick();
    chk("ack_err_stays_clr", 32'(ack_err), 0);
`endif

    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_busy", 32'(busy), 0);
    chk("final_no_overflow", 32'(real_ovf), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
